// File: rtl/sincronizador_multicanal_pkg.sv
// Shared defaults and width helpers for the multi-lane receiver synchronizer.
// No logic; imported by the lane and top modules.
package sincronizador_multicanal_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_STAGES     = 2;
    localparam int DEF_FILTER     = 3;
    localparam int DEF_LOS_CYCLES = 16;

    // Filter counter must hold 0..FILTER-1 and never collapse to zero width.
    function automatic int cntWidth(input int filterLen);
        return (filterLen > 1) ? $clog2(filterLen) : 1;
    endfunction

endpackage

// File: rtl/sincronizador_multicanal_canal.sv
// One lane: sync chain, glitch filter, edge pulses and loss-of-signal flag.
// Latency STAGES+FILTER edges from input to dataSync; no backpressure, enb only freezes filter/LOS.
module sincronizador_canal
    import sincronizador_multicanal_pkg::*;
#(
    parameter int STAGES     = DEF_STAGES,
    parameter int FILTER     = DEF_FILTER,
    parameter int LOS_CYCLES = DEF_LOS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    input  logic dataAsync,
    output logic dataSync,
    output logic risePulse,
    output logic fallPulse,
    output logic los
);

    localparam int CW = cntWidth(FILTER);
    localparam int LW = $clog2(LOS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);
    localparam logic [LW-1:0] LOS_MAX = LW'(LOS_CYCLES);

    logic [STAGES-1:0] st;
    logic [CW-1:0]     cnt;
    logic [LW-1:0]     losCnt;
    logic              raw;
    logic              update;

    assign raw    = st[STAGES-1];
    assign update = enb && (raw != dataSync) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= '0;
            cnt       <= '0;
            dataSync  <= 1'b0;
            risePulse <= 1'b0;
            fallPulse <= 1'b0;
            losCnt    <= '0;
            los       <= 1'b1;
        end else begin
            st        <= {st[STAGES-2:0], dataAsync};
            risePulse <= update && raw;
            fallPulse <= update && !raw;
            if (enb) begin
                if (raw == dataSync) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    dataSync <= raw;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // Counter saturates so los stays asserted through long idle periods.
                if (update) begin
                    losCnt <= '0;
                    los    <= 1'b0;
                end else if (losCnt != LOS_MAX) begin
                    losCnt <= losCnt + 1'b1;
                    if (losCnt == LOS_MAX - 1'b1) begin
                        los <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sincronizador_multicanal.sv
// LANES independent receiver synchronizers side by side; no logic crosses lanes.
// Latency STAGES+FILTER edges per lane; no backpressure.
module sincronizador_multicanal
    import sincronizador_multicanal_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int STAGES     = DEF_STAGES,
    parameter int FILTER     = DEF_FILTER,
    parameter int LOS_CYCLES = DEF_LOS_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [LANES-1:0] dataAsync,
    output logic [LANES-1:0] dataSync,
    output logic [LANES-1:0] risePulse,
    output logic [LANES-1:0] fallPulse,
    output logic [LANES-1:0] los
);

    for (genvar g = 0; g < LANES; g++) begin : gLane
        sincronizador_canal #(
            .STAGES    (STAGES),
            .FILTER    (FILTER),
            .LOS_CYCLES(LOS_CYCLES)
        ) uCanal (
            .clk      (clk),
            .rst      (rst),
            .enb      (enb),
            .dataAsync(dataAsync[g]),
            .dataSync (dataSync[g]),
            .risePulse(risePulse[g]),
            .fallPulse(fallPulse[g]),
            .los      (los[g])
        );
    end

endmodule

// File: tb/tb_sincronizador_multicanal.sv
// Scoreboard bench: stimulus pushes expected level snapshots and pulse events per cycle,
// a negedge monitor pops and compares them; any pulse not announced is flagged.
module tb_sincronizador_multicanal;

    typedef struct {
        int         cyc;
        logic [3:0] ds;
        logic [3:0] los;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } pulse_t;

    logic       clk;
    logic       rst;
    logic       enb;
    logic [3:0] dataAsync;
    logic [3:0] dataSync;
    logic [3:0] risePulse;
    logic [3:0] fallPulse;
    logic [3:0] los;

    bit     clkRun = 0;
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    snap_t  snapQ[$];
    pulse_t pulseQ[$];
    snap_t  sMon;
    pulse_t pMon;

    sincronizador_multicanal #(
        .LANES(4), .STAGES(2), .FILTER(3), .LOS_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .dataAsync(dataAsync),
        .dataSync (dataSync),
        .risePulse(risePulse),
        .fallPulse(fallPulse),
        .los      (los)
    );

    initial begin
        clk = 1'b0;
        wait (clkRun);
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expSnap(input int c, input logic [3:0] ds, input logic [3:0] l);
        snap_t s;
        s.cyc = c; s.ds = ds; s.los = l;
        snapQ.push_back(s);
    endtask

    task automatic expPulse(input int c, input logic [3:0] r, input logic [3:0] f);
        pulse_t p;
        p.cyc = c; p.rise = r; p.fall = f;
        pulseQ.push_back(p);
    endtask

    always @(negedge clk) begin
        while (snapQ.size() > 0 && snapQ[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL snapshot_missed: due cycle %0d, now %0d", snapQ[0].cyc, cyc);
            void'(snapQ.pop_front());
        end
        if (snapQ.size() > 0 && snapQ[0].cyc == cyc) begin
            sMon = snapQ.pop_front();
            check("dataSync", dataSync, sMon.ds);
            check("los", los, sMon.los);
        end
        if (pulseQ.size() > 0 && pulseQ[0].cyc == cyc) begin
            pMon = pulseQ.pop_front();
            check("risePulse", risePulse, pMon.rise);
            check("fallPulse", fallPulse, pMon.fall);
        end else if ((risePulse | fallPulse) != 4'h0) begin
            checks++; failures++;
            $display("FAIL unexpected_pulse at cycle %0d: rise=%h fall=%h, want none",
                     cyc, risePulse, fallPulse);
        end
    end

    initial begin
        int c;
        int t2;
        int c2;
        int r;
        rst = 1'b1; enb = 1'b0; dataAsync = 4'h0;

        // Reset with the clock stopped must take effect at once.
        #1 rst = 1'b0;
        #1;
        check("reset_dataSync", dataSync, 4'h0);
        check("reset_rise", risePulse, 4'h0);
        check("reset_fall", fallPulse, 4'h0);
        check("reset_los", los, 4'hF);

        clkRun = 1;
        tick(2);
        rst = 1'b1; enb = 1'b1;
        tick(3);

        // Lane 0 rises: visible after STAGES+FILTER edges, los then re-arms.
        c = cyc;
        dataAsync[0] = 1'b1;
        expSnap(c + 4, 4'h0, 4'hF);
        expSnap(c + 5, 4'h1, 4'hE);
        expPulse(c + 5, 4'h1, 4'h0);
        expSnap(c + 20, 4'h1, 4'hE);
        expSnap(c + 21, 4'h1, 4'hF);
        tick(25);

        // Lane 1 glitch of 2 cycles is rejected.
        c = cyc;
        dataAsync[1] = 1'b1;
        tick(2);
        dataAsync[1] = 1'b0;
        expSnap(c + 8, 4'h1, 4'hF);
        tick(10);

        // enb=0 freezes outputs; re-enable completes the filter in 3 edges.
        c = cyc;
        enb = 1'b0;
        dataAsync = 4'hF;
        expSnap(c + 10, 4'h1, 4'hF);
        tick(10);
        c = cyc;
        enb = 1'b1;
        expSnap(c + 2, 4'h1, 4'hF);
        expSnap(c + 3, 4'hF, 4'h1);
        expPulse(c + 3, 4'hE, 4'h0);
        tick(5);

        // Lane 2 falls, goes idle until los, then rises again.
        c = cyc;
        t2 = c + 5;
        dataAsync[2] = 1'b0;
        expSnap(t2, 4'hB, 4'h1);
        expPulse(t2, 4'h0, 4'h4);
        expSnap(t2 + 15, 4'hB, 4'hB);
        expSnap(t2 + 16, 4'hB, 4'hF);
        tick(25);
        c2 = cyc;
        dataAsync[2] = 1'b1;
        expSnap(c2 + 4, 4'hB, 4'hF);
        expSnap(c2 + 5, 4'hF, 4'hB);
        expPulse(c2 + 5, 4'h4, 4'h0);
        tick(8);

        // Lane 3 mid-filter (cnt=2) when reset hits; restarts from scratch.
        dataAsync[3] = 1'b0;
        tick(4);
        #1 rst = 1'b0;
        dataAsync = 4'hF;
        #1;
        check("midreset_dataSync", dataSync, 4'h0);
        check("midreset_rise", risePulse, 4'h0);
        check("midreset_fall", fallPulse, 4'h0);
        check("midreset_los", los, 4'hF);
        #1 rst = 1'b1;
        r = cyc;
        expSnap(r + 4, 4'h0, 4'hF);
        expSnap(r + 5, 4'hF, 4'h0);
        expPulse(r + 5, 4'hF, 4'h0);
        tick(10);

        checks++;
        if (snapQ.size() != 0 || pulseQ.size() != 0) begin
            failures++;
            $display("FAIL queues_drained: snapshots=%0d pulses=%0d left, want 0",
                     snapQ.size(), pulseQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
